// File: rtl/tt_vpu_lq_pkg.sv
// Shared load-queue types, widths and helpers for the VPU load path.
`timescale 1ns/1ps
package tt_vpu_lq_pkg;

    localparam int unsigned LQ_DEPTH = 8;
    localparam int unsigned LQID_W   = 3;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SB_ID_W  = 5;

    // Drain command as issued by the scoreboard.
    typedef struct packed {
        logic [LQID_W-1:0]  lqid_start;
        logic [CNT_W-1:0]   ref_count;
        logic [SB_ID_W-1:0] sb_id;
    } drain_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } lq_drain_state_e;

    // Circular LQ index increment; depth is a power of two so the wrap is free.
    function automatic logic [LQID_W-1:0] lqid_inc(input logic [LQID_W-1:0] lqid);
        return lqid + LQID_W'(1);
    endfunction

endpackage

// File: rtl/tt_lq_drain_ctrl.sv
// Walks one vector load's LQ entries into the VRF write port, one entry at a time.
`timescale 1ns/1ps
module tt_lq_drain_ctrl
    import tt_vpu_lq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_drain_req,
    input  logic [CNT_W-1:0]    i_drain_ref_count,
    input  logic [LQID_W-1:0]   i_drain_lqid_start,
    input  logic [SB_ID_W-1:0]  i_drain_sb_id,
    input  logic [LQ_DEPTH-1:0] i_lq_data_valid,
    input  logic                i_kill,
    output logic                o_draining,
    output logic                o_vrf_wr_req,
    output logic [LQID_W-1:0]   o_vrf_wr_lqid,
    input  logic                i_vrf_wr_gnt,
    output logic                o_lq_commit,
    output logic [LQID_W-1:0]   o_commit_lqid,
    output logic                o_drain_done,
    output logic [SB_ID_W-1:0]  o_done_sb_id
);

    lq_drain_state_e    state_q;
    logic [LQID_W-1:0]  cur_lqid_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [SB_ID_W-1:0] sb_id_q;
    drain_cmd_t         cmd;
    logic               abort;

    assign cmd   = '{lqid_start: i_drain_lqid_start,
                     ref_count:  i_drain_ref_count,
                     sb_id:      i_drain_sb_id};
    // Reset in flight behaves like a kill for the outputs of the current cycle.
    assign abort = i_kill | reset;

    // Drain sequencer: state, walk pointer, remaining count and owning sb_id.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_lqid_q  <= '0;
            remaining_q <= '0;
            sb_id_q     <= '0;
        end else if (i_kill) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_drain_req) begin
                        cur_lqid_q  <= cmd.lqid_start;
                        remaining_q <= cmd.ref_count;
                        sb_id_q     <= cmd.sb_id;
                        state_q     <= (cmd.ref_count == '0) ? ST_DONE : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (i_lq_data_valid[cur_lqid_q]) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_vrf_wr_gnt) begin
                        cur_lqid_q <= lqid_inc(cur_lqid_q);
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                        state_q <= (remaining_q <= CNT_W'(1)) ? ST_DONE : ST_WAIT_DATA;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register; kill suppresses write, commit and done.
    always_comb begin
        o_draining    = 1'b0;
        o_vrf_wr_req  = 1'b0;
        o_vrf_wr_lqid = '0;
        o_lq_commit   = 1'b0;
        o_commit_lqid = '0;
        o_drain_done  = 1'b0;
        o_done_sb_id  = '0;

        o_draining = (state_q != ST_IDLE);

        if (state_q == ST_WRITE && !abort) begin
            o_vrf_wr_req  = 1'b1;
            o_vrf_wr_lqid = cur_lqid_q;
            if (i_vrf_wr_gnt) begin
                o_lq_commit   = 1'b1;
                o_commit_lqid = cur_lqid_q;
            end
        end

        if (state_q == ST_DONE && !abort) begin
            o_drain_done = 1'b1;
            o_done_sb_id = sb_id_q;
        end
    end

endmodule

// File: tb/tb_tt_lq_drain_ctrl.sv
// Directed self-checking bench for the LQ drain sequencer.
`timescale 1ns/1ps
module tb_tt_lq_drain_ctrl;

    logic       clk;
    logic       reset;
    logic       drain_req;
    logic [2:0] drain_ref_count;
    logic [2:0] drain_lqid_start;
    logic [4:0] drain_sb_id;
    logic [7:0] lq_data_valid;
    logic       kill;
    logic       draining;
    logic       vrf_wr_req;
    logic [2:0] vrf_wr_lqid;
    logic       vrf_wr_gnt;
    logic       lq_commit;
    logic [2:0] commit_lqid;
    logic       drain_done;
    logic [4:0] done_sb_id;

    int checks   = 0;
    int failures = 0;

    tt_lq_drain_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .i_drain_req        (drain_req),
        .i_drain_ref_count  (drain_ref_count),
        .i_drain_lqid_start (drain_lqid_start),
        .i_drain_sb_id      (drain_sb_id),
        .i_lq_data_valid    (lq_data_valid),
        .i_kill             (kill),
        .o_draining         (draining),
        .o_vrf_wr_req       (vrf_wr_req),
        .o_vrf_wr_lqid      (vrf_wr_lqid),
        .i_vrf_wr_gnt       (vrf_wr_gnt),
        .o_lq_commit        (lq_commit),
        .o_commit_lqid      (commit_lqid),
        .o_drain_done       (drain_done),
        .o_done_sb_id       (done_sb_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge of the current cycle, then advance past the next rising edge.
    // Index outputs are only compared while their qualifying strobe is expected high.
    task automatic cyc(input string tag, input logic dr, input logic wr, input logic [2:0] wl,
                       input logic cm, input logic [2:0] cl, input logic dn, input logic [4:0] ds);
        @(negedge clk);
        chk({tag, ".draining"}, 32'(draining), 32'(dr));
        chk({tag, ".wr_req"},   32'(vrf_wr_req), 32'(wr));
        if (wr) chk({tag, ".wr_lqid"}, 32'(vrf_wr_lqid), 32'(wl));
        chk({tag, ".commit"},   32'(lq_commit), 32'(cm));
        if (cm) chk({tag, ".commit_lqid"}, 32'(commit_lqid), 32'(cl));
        chk({tag, ".done"},     32'(drain_done), 32'(dn));
        if (dn) chk({tag, ".done_sb"}, 32'(done_sb_id), 32'(ds));
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] start, input logic [2:0] cnt, input logic [4:0] sb);
        drain_req        = 1'b1;
        drain_lqid_start = start;
        drain_ref_count  = cnt;
        drain_sb_id      = sb;
    endtask

    logic [2:0] exp_l [3];

    initial begin
        reset = 1'b1; drain_req = 1'b0; drain_ref_count = '0; drain_lqid_start = '0;
        drain_sb_id = '0; lq_data_valid = '0; kill = 1'b0; vrf_wr_gnt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("idle0", 0, 0, 0, 0, 0, 0, 0);

        // Single entry: start 2, commit at T2, done at T3, idle at T4.
        lq_data_valid = 8'hFF; vrf_wr_gnt = 1'b1;
        cmd(3'd2, 3'd1, 5'd9);
        cyc("s1.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        cyc("s1.T1", 1, 0, 0, 0, 0, 0, 0);
        cyc("s1.T2", 1, 1, 2, 1, 2, 0, 0);
        cyc("s1.T3", 1, 0, 0, 0, 0, 1, 9);
        cyc("s1.T4", 0, 0, 0, 0, 0, 0, 0);

        // Three entries wrapping 6,7,0; done at T7.
        exp_l[0] = 3'd6; exp_l[1] = 3'd7; exp_l[2] = 3'd0;
        cmd(3'd6, 3'd3, 5'd3);
        cyc("s2.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("s2.wait%0d", k), 1, 0, 0, 0, 0, 0, 0);
            cyc($sformatf("s2.wr%0d", k), 1, 1, exp_l[k], 1, exp_l[k], 0, 0);
        end
        cyc("s2.T7", 1, 0, 0, 0, 0, 1, 3);
        cyc("s2.T8", 0, 0, 0, 0, 0, 0, 0);

        // Zero-count drain: done at T1, no write, no commit.
        cmd(3'd5, 3'd0, 5'd17);
        cyc("s3.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        cyc("s3.T1", 1, 0, 0, 0, 0, 1, 17);
        cyc("s3.T2", 0, 0, 0, 0, 0, 0, 0);

        // Data late and grant withheld: request held stable, commit only on grant.
        lq_data_valid = 8'h00; vrf_wr_gnt = 1'b0;
        cmd(3'd0, 3'd2, 5'd5);
        cyc("s4.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        for (int k = 1; k <= 4; k++) cyc($sformatf("s4.T%0d", k), 1, 0, 0, 0, 0, 0, 0);
        lq_data_valid = 8'h01;
        cyc("s4.T5", 1, 0, 0, 0, 0, 0, 0);
        cyc("s4.T6", 1, 1, 0, 0, 0, 0, 0);
        lq_data_valid = 8'h00;
        cyc("s4.T7", 1, 1, 0, 0, 0, 0, 0);
        cyc("s4.T8", 1, 1, 0, 0, 0, 0, 0);
        vrf_wr_gnt = 1'b1;
        cyc("s4.T9", 1, 1, 0, 1, 0, 0, 0);
        vrf_wr_gnt = 1'b0; lq_data_valid = 8'h02;
        cyc("s4.T10", 1, 0, 0, 0, 0, 0, 0);
        vrf_wr_gnt = 1'b1;
        cyc("s4.T11", 1, 1, 1, 1, 1, 0, 0);
        cyc("s4.T12", 1, 0, 0, 0, 0, 1, 5);
        cyc("s4.T13", 0, 0, 0, 0, 0, 0, 0);

        // Kill on the second grant: one commit only, no done; kill in IDLE blocks acceptance.
        lq_data_valid = 8'hFF;
        cmd(3'd4, 3'd3, 5'd11);
        cyc("s5.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        cyc("s5.T1", 1, 0, 0, 0, 0, 0, 0);
        cyc("s5.T2", 1, 1, 4, 1, 4, 0, 0);
        cyc("s5.T3", 1, 0, 0, 0, 0, 0, 0);
        kill = 1'b1;
        cyc("s5.kill", 1, 0, 0, 0, 0, 0, 0);
        cmd(3'd1, 3'd1, 5'd20);
        cyc("s5.T5", 0, 0, 0, 0, 0, 0, 0);
        kill = 1'b0;
        cyc("s5.blocked", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        cyc("s5.accepted", 1, 0, 0, 0, 0, 0, 0);
        cyc("s5.wr", 1, 1, 1, 1, 1, 0, 0);
        cyc("s5.done", 1, 0, 0, 0, 0, 1, 20);
        cyc("s5.idle", 0, 0, 0, 0, 0, 0, 0);

        // Request while busy is ignored; done carries the original sb_id.
        cmd(3'd3, 3'd2, 5'd7);
        cyc("s6.T0", 0, 0, 0, 0, 0, 0, 0);
        cmd(3'd5, 3'd0, 5'd30);
        cyc("s6.T1", 1, 0, 0, 0, 0, 0, 0);
        cyc("s6.T2", 1, 1, 3, 1, 3, 0, 0);
        cyc("s6.T3", 1, 0, 0, 0, 0, 0, 0);
        cyc("s6.T4", 1, 1, 4, 1, 4, 0, 0);
        cyc("s6.T5", 1, 0, 0, 0, 0, 1, 7);
        drain_req = 1'b0;
        cyc("s6.T6", 0, 0, 0, 0, 0, 0, 0);

        // Reset while in WRITE: outputs gated in that cycle, all zero after.
        vrf_wr_gnt = 1'b0;
        cmd(3'd1, 3'd2, 5'd12);
        cyc("s7.T0", 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b0;
        cyc("s7.T1", 1, 0, 0, 0, 0, 0, 0);
        cyc("s7.T2", 1, 1, 1, 0, 0, 0, 0);
        reset = 1'b1; vrf_wr_gnt = 1'b1;
        cyc("s7.rst", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("s7.T4", 0, 0, 0, 0, 0, 0, 0);
        cyc("s7.T5", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
